rv32imf_obi_arbiter: RTL and testbench

- Shares one OBI memory port between the instruction prefetch master (port I) and the load/store master (port D).
- Picks one requester per cycle, with round-robin or fixed data priority. Holds the pick stable until the memory grants it.
- Records which master issued each outstanding transaction and routes in-order responses back to that master.
- Sits between the prefetch buffer / LSU and the single external memory interface.

---
 rtl/rv32imf_obi_arbiter.sv | 167 ++++++++++++++++
 tb/tb_rv32imf_obi_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rv32imf_obi_arbiter.sv
// Two-master OBI arbiter: shares one memory port between instruction fetch (I)
// and load/store (D), tracks the owner of each outstanding transaction and routes responses back.
module rv32imf_obi_arbiter #(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned DATA_PRIORITY   = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_req_i,
   output logic        instr_gnt_o,
   input  logic [31:0] instr_addr_i,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   input  logic        data_req_i,
   output logic        data_gnt_o,
   input  logic [31:0] data_addr_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   output logic        mem_req_o,
   input  logic        mem_gnt_i,
   output logic [31:0] mem_addr_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_err_i,
   output logic        busy_o,
   output logic        protocol_err_o
);

   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic        ID_I  = 1'b0;
   localparam logic        ID_D  = 1'b1;

   typedef enum logic [1:0] {
      ST_ARB,
      ST_LOCK_I,
      ST_LOCK_D
   } state_e;

   state_e                     state_q, state_d;
   logic                       rr_last_q, rr_last_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
   logic [MAX_OUTSTANDING-1:0] id_fifo_q, id_fifo_d;
   logic                       prot_err_q, prot_err_d;

   logic empty, full, space, winner, sel, req, hs, push, pop, head;

   // Arbitration, handshake and ID FIFO bookkeeping
   always_comb begin
      state_d    = state_q;
      rr_last_d  = rr_last_q;
      cnt_d      = cnt_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      id_fifo_d  = id_fifo_q;
      prot_err_d = 1'b0;
      sel        = ID_I;
      req        = 1'b0;

      empty = (cnt_q == '0);
      full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
      space = !full || mem_rvalid_i;
      head  = id_fifo_q[rd_ptr_q];

      if (instr_req_i && data_req_i) begin
         winner = (DATA_PRIORITY != 0) ? ID_D : ~rr_last_q;
      end else begin
         winner = data_req_i ? ID_D : ID_I;
      end

      case (state_q)
         ST_LOCK_I: begin
            sel = ID_I;
            req = 1'b1;
         end
         ST_LOCK_D: begin
            sel = ID_D;
            req = 1'b1;
         end
         default: begin
            sel = winner;
            req = (instr_req_i || data_req_i) && space;
         end
      endcase

      hs   = req && mem_gnt_i;
      push = hs;
      pop  = mem_rvalid_i && !empty;

      if (hs) begin
         rr_last_d = sel;
         state_d   = ST_ARB;
      end else if (req && state_q == ST_ARB) begin
         state_d = (sel == ID_D) ? ST_LOCK_D : ST_LOCK_I;
      end

      if (push) begin
         id_fifo_d[wr_ptr_q] = sel;
         wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end

      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase

      prot_err_d = mem_rvalid_i && empty;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_ARB;
         rr_last_q  <= ID_D;
         cnt_q      <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         id_fifo_q  <= '0;
         prot_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_last_q  <= rr_last_d;
         cnt_q      <= cnt_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         id_fifo_q  <= id_fifo_d;
         prot_err_q <= prot_err_d;
      end
   end

   // Handshake outputs are forced low while reset is held, even with requests present
   assign mem_req_o   = req && !rst;
   assign instr_gnt_o = hs && (sel == ID_I) && !rst;
   assign data_gnt_o  = hs && (sel == ID_D) && !rst;

   assign mem_addr_o  = (sel == ID_D) ? data_addr_i  : instr_addr_i;
   assign mem_we_o    = (sel == ID_D) ? data_we_i    : 1'b0;
   assign mem_be_o    = (sel == ID_D) ? data_be_i    : 4'b1111;
   assign mem_wdata_o = (sel == ID_D) ? data_wdata_i : 32'h0;

   assign instr_rvalid_o = pop && (head == ID_I) && !rst;
   assign data_rvalid_o  = pop && (head == ID_D) && !rst;
   assign instr_rdata_o  = mem_rdata_i;
   assign data_rdata_o   = mem_rdata_i;
   assign instr_err_o    = mem_err_i;
   assign data_err_o     = mem_err_i;

   assign busy_o         = ((cnt_q != '0) || (state_q != ST_ARB)) && !rst;
   assign protocol_err_o = prot_err_q;

   // Grant into a full FIFO without a simultaneous pop would lose an ID
   assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: tb/tb_rv32imf_obi_arbiter.sv
// Directed bench for rv32imf_obi_arbiter (MAX_OUTSTANDING=2, round-robin).
module tb_rv32imf_obi_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
   logic [31:0] instr_addr_i, instr_rdata_o;
   logic        data_req_i, data_gnt_o, data_we_i, data_rvalid_o, data_err_o;
   logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
   logic [3:0]  data_be_i, mem_be_o;
   logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i, mem_err_i;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic        busy_o, protocol_err_o;

   int n_checks = 0;
   int n_err    = 0;

   rv32imf_obi_arbiter #(.MAX_OUTSTANDING(2), .DATA_PRIORITY(0)) dut (
      .clk(clk), .rst(rst),
      .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_addr_i(instr_addr_i),
      .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
      .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_addr_i(data_addr_i),
      .data_we_i(data_we_i), .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
      .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
      .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
      .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
      .busy_o(busy_o), .protocol_err_o(protocol_err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      instr_req_i = 0; instr_addr_i = 0;
      data_req_i = 0; data_addr_i = 0; data_we_i = 0; data_be_i = 0; data_wdata_i = 0;
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0; mem_err_i = 0;
   endtask

   // Inputs change just after a falling edge; outputs are sampled 1ns later
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      idle();
      @(negedge clk);
      #1;
      chk("rst_mem_req", mem_req_o, 0);
      chk("rst_gnt", {instr_gnt_o, data_gnt_o}, 0);
      chk("rst_rvalid", {instr_rvalid_o, data_rvalid_o}, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_perr", protocol_err_o, 0);
      rst = 1'b0;
      cyc();

      // Single instruction fetch, response two cycles after grant
      instr_req_i = 1; instr_addr_i = 32'h100; mem_gnt_i = 1;
      #1;
      chk("t1_mem_req", mem_req_o, 1);
      chk("t1_igrant", instr_gnt_o, 1);
      chk("t1_dgrant", data_gnt_o, 0);
      chk("t1_addr", mem_addr_o, 32'h100);
      chk("t1_be_we", {mem_be_o, mem_we_o}, {4'b1111, 1'b0});
      chk("t1_wdata", mem_wdata_o, 0);
      cyc();
      idle();
      #1;
      chk("t1_busy_wait", busy_o, 1);
      cyc();
      mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
      #1;
      chk("t1_irvalid", instr_rvalid_o, 1);
      chk("t1_irdata", instr_rdata_o, 32'hDEADBEEF);
      chk("t1_drvalid", data_rvalid_o, 0);
      cyc();
      idle();
      #1;
      chk("t1_busy_done", busy_o, 0);

      // Reset so the first tie goes to I again
      rst = 1'b1;
      #1;
      rst = 1'b0;
      cyc();

      // Continuous contention: grants alternate I,D,I,D; each response one cycle later
      for (int k = 0; k < 5; k++) begin
         instr_req_i = (k < 4); data_req_i = (k < 4);
         instr_addr_i = 32'h400 + 32'(k); data_addr_i = 32'h800 + 32'(k);
         mem_gnt_i = (k < 4);
         mem_rvalid_i = (k >= 1); mem_rdata_i = 32'h1000 + 32'(k);
         #1;
         if (k < 4) begin
            chk($sformatf("t2_igrant%0d", k), instr_gnt_o, ((k % 2) == 0) ? 1 : 0);
            chk($sformatf("t2_dgrant%0d", k), data_gnt_o,  ((k % 2) == 1) ? 1 : 0);
            chk($sformatf("t2_addr%0d", k), mem_addr_o,
                ((k % 2) == 0) ? 32'h400 + 32'(k) : 32'h800 + 32'(k));
         end
         if (k >= 1) begin
            chk($sformatf("t2_irv%0d", k), instr_rvalid_o, (((k - 1) % 2) == 0) ? 1 : 0);
            chk($sformatf("t2_drv%0d", k), data_rvalid_o,  (((k - 1) % 2) == 1) ? 1 : 0);
         end
         cyc();
      end
      idle();
      #1;
      chk("t2_idle_busy", busy_o, 0);

      // D request stalled by memory for 3 cycles; I joins in cycle 1 but must wait
      for (int k = 0; k < 4; k++) begin
         data_req_i = 1; data_addr_i = 32'h200; data_we_i = 1; data_be_i = 4'b0011;
         data_wdata_i = 32'h55AA;
         instr_req_i = (k >= 1); instr_addr_i = 32'h300;
         mem_gnt_i = (k == 3);
         #1;
         chk($sformatf("t3_addr%0d", k), mem_addr_o, 32'h200);
         chk($sformatf("t3_we_be%0d", k), {mem_we_o, mem_be_o}, {1'b1, 4'b0011});
         chk($sformatf("t3_dgnt%0d", k), data_gnt_o, (k == 3) ? 1 : 0);
         chk($sformatf("t3_ignt%0d", k), instr_gnt_o, 0);
         cyc();
      end
      data_req_i = 0; data_we_i = 0; data_be_i = 0;
      mem_gnt_i = 1;
      #1;
      chk("t3_i_after", instr_gnt_o, 1);
      chk("t3_i_addr", mem_addr_o, 32'h300);
      chk("t3_i_wdata", mem_wdata_o, 0);
      cyc();

      // FIFO full (D then I outstanding): request held back until a response frees a slot
      instr_addr_i = 32'h304;
      #1;
      chk("t4_full_req", mem_req_o, 0);
      chk("t4_full_gnt", instr_gnt_o, 0);
      chk("t4_full_busy", busy_o, 1);
      cyc();
      mem_rvalid_i = 1; mem_rdata_i = 32'hA5A5_0001;
      #1;
      chk("t4_rv_req", mem_req_o, 1);
      chk("t4_rv_gnt", instr_gnt_o, 1);
      chk("t4_rv_drv", data_rvalid_o, 1);
      chk("t4_rv_irv", instr_rvalid_o, 0);
      cyc();
      mem_rvalid_i = 0;
      #1;
      chk("t4_still_full", mem_req_o, 0);
      cyc();
      // Response frees a slot without a grant: arbiter locks onto I
      mem_rvalid_i = 1; mem_gnt_i = 0; mem_rdata_i = 32'hA5A5_0002;
      #1;
      chk("t4_lock_req", mem_req_o, 1);
      chk("t4_lock_irv", instr_rvalid_o, 1);
      cyc();
      mem_rvalid_i = 0;
      #1;
      chk("t4_locked_req", mem_req_o, 1);
      chk("t4_locked_addr", mem_addr_o, 32'h304);

      // Asynchronous reset while locked with an ID pending
      rst = 1'b1; data_req_i = 1; mem_gnt_i = 1;
      #1;
      chk("t6_rst_req", mem_req_o, 0);
      chk("t6_rst_gnt", {instr_gnt_o, data_gnt_o}, 0);
      chk("t6_rst_busy", busy_o, 0);
      cyc();
      idle();
      rst = 1'b0;
      #1;
      chk("t6_rel_busy", busy_o, 0);

      // Response after reset is unexpected: dropped, one-cycle protocol error
      mem_rvalid_i = 1; mem_rdata_i = 32'hBAD0BAD0;
      #1;
      chk("t5_irv", instr_rvalid_o, 0);
      chk("t5_drv", data_rvalid_o, 0);
      cyc();
      mem_rvalid_i = 0;
      #1;
      chk("t5_perr_hi", protocol_err_o, 1);
      cyc();
      #1;
      chk("t5_perr_lo", protocol_err_o, 0);

      // First tie after reset goes to I
      instr_req_i = 1; data_req_i = 1; mem_gnt_i = 1;
      instr_addr_i = 32'h500; data_addr_i = 32'h600;
      #1;
      chk("t6_tie_i", instr_gnt_o, 1);
      chk("t6_tie_d", data_gnt_o, 0);
      chk("t6_tie_addr", mem_addr_o, 32'h500);
      cyc();
      idle();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
